audio_pdm_dac: RTL and testbench
================================

Name: audio_pdm_dac

Overview:
- Output stage directly downstream of the audio copper's 8-bit audio_out.
- Buffers offset-binary samples in a small FIFO and releases one per playback-rate strobe.
- Applies volume and mute, then drives a single-bit pin as either PWM or first-order sigma-delta (PDM) for an external RC filter.
- Contains a startup ramp so the pin does not click on power-up or reset.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, at least 2.
- RAMP_DIV, 256, clk50MHz cycles per 1-LSB startup ramp step; at least 1.

Ports:
- clk50MHz  in  1  system clock.
- reset  in  1  active-high reset.
- sample_in  in  8  unsigned offset-binary sample; 0x80 = silence.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  FIFO can accept a sample; equals !full.
- sample_tick  in  1  one-cycle playback-rate strobe.
- mode  in  1  0 = PWM, 1 = sigma-delta.
- volume  in  3  attenuation, as an arithmetic right shift of 0..7.
- mute  in  1  force the output target to midscale.
- underrun  out  1  one-cycle pulse: a tick found the FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- pdm_out  out  1  registered audio pin.

Behaviour:
- Interface: one clock, clk50MHz. Reset is asynchronous, active-high, named reset.
- Reset values:
  - pdm_out = 0, underrun = 0, fifo_level = 0, sample_ready = 1.
  - FIFO pointers cleared, cur_sample = 0x80, lvl = 0x00.
  - PWM counter and sigma-delta accumulator = 0; state = RAMP_UP.
  - Reset mid-operation discards all queued samples and restarts the ramp.
- FIFO:
  - A push occurs when sample_valid && sample_ready.
  - Pointers wrap modulo FIFO_DEPTH.
  - Occupancy is held in fifo_level; sample_ready = (fifo_level != FIFO_DEPTH).
  - If a push and a pop happen in the same cycle on a full FIFO, the pop is performed; the push cannot occur because sample_ready is low.
- State RAMP_UP:
  - lvl increments by 1 each time the ramp counter reaches RAMP_DIV-1; the counter then wraps to 0.
  - When lvl reaches 0x80, the next state is RUN.
  - Pushes are accepted; sample_tick is ignored (no pop, no underrun).
- State RUN, on sample_tick:
  - If fifo_level > 0: pop the FIFO head into cur_sample, one cycle later.
  - If fifo_level == 0: cur_sample is held, and underrun is asserted on the following cycle for exactly one cycle.
  - A push and a tick in the same cycle on an empty FIFO count as an underrun; the pushed sample is stored.
- Target level (RUN), combinational from registered inputs:
  - s = {1'b0, cur_sample} - 128, as a 9-bit signed value.
  - t = (s >>> volume) + 128, truncated to 8 bits.
  - If mute = 1, t = 0x80.
  - lvl <= t every cycle; one cycle of latency from cur_sample, volume or mute to lvl.
- PWM, mode = 0:
  - pwm_cnt is an 8-bit free-running counter, 0..255, that wraps.
  - pwm_lvl <= lvl only when pwm_cnt == 255, giving glitch-free period boundaries.
  - pdm_out <= (pwm_cnt < pwm_lvl).
  - lvl = 0 gives constant 0; lvl = 255 gives 255 of 256 cycles high.
- Sigma-delta, mode = 1:
  - acc is a 9-bit register; acc <= {1'b0, acc[7:0]} + lvl; pdm_out <= that sum's bit 8.
  - Over any 256 cycles of constant lvl, the count of ones equals lvl exactly.
- Mode change:
  - Takes effect on the next cycle.
  - The accumulator and counter keep running in both modes; no reset on a switch.
- Outputs:
  - pdm_out is always a register output.
  - underrun and fifo_level are registered.

Test Plan:
- RAMP_DIV=4, mode=0, no samples → lvl reaches 0x80 after 512 cycles; afterwards pdm_out is high for exactly 128 of every 256 cycles; ticks during the ramp produce no underrun.
- Push 0xC0, 0x40, 0xFF, 0x00 back-to-back → fifo_level = 4, sample_ready = 0; a 5th push is refused; four ticks deliver the samples in order, and fifo_level returns to 0.
- PWM, cur_sample 0xC0: volume 0 gives 192 highs per period; volume 1 gives lvl 0xA0 (160 highs). Sample 0x40 at volume 1 gives lvl 0x60. Volume 7 on 0x00 gives lvl 0x7F.
- mode=1, sample 0x40, volume 0 → exactly 64 ones in any 256-cycle window; sample 0x00 → pdm_out constantly 0.
- Tick with an empty FIFO in RUN → underrun high for one cycle and lvl unchanged; a simultaneous push and tick on an empty FIFO → underrun plus fifo_level = 1.
- mute=1 during 0xFF playback → 128 highs per PWM period from the next boundary. Asserting reset mid-stream → pdm_out 0 immediately, fifo_level 0, and the ramp restarts from 0.

Source files
------------

// File: rtl/audio_pdm_dac.sv
// Audio output stage: small sample FIFO, volume/mute scaling, click-free startup
// ramp, and a one-bit PWM or first-order sigma-delta modulator for an RC filter.
module audio_pdm_dac #(
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_DIV   = 256
) (
    input  logic                        clk50MHz,
    input  logic                        reset,
    input  logic [7:0]                  sample_in,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic                        sample_tick,
    input  logic                        mode,
    input  logic [2:0]                  volume,
    input  logic                        mute,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        pdm_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_DIV - 1);
    localparam logic [7:0]        MIDSCALE   = 8'h80;

    typedef enum logic {
        RAMP_UP = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t            state_reg;
    logic [RAMP_W-1:0] ramp_cnt_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [LVL_W-1:0]  level_reg;
    logic [LVL_W-1:0]  level_next;
    logic [7:0]        cur_sample_reg;
    logic [7:0]        lvl_reg;
    logic              underrun_reg;
    logic [7:0]        fifo_mem [FIFO_DEPTH];

    logic [7:0]        pwm_cnt_reg;
    logic [7:0]        pwm_lvl_reg;
    logic [7:0]        acc_reg;
    logic              pdm_reg;
    logic [8:0]        sd_sum;

    logic              push;
    logic              pop;
    logic              tick_empty;

    logic signed [8:0] centered;
    logic [7:0]        shifted [8];
    logic [7:0]        target_level;

    assign sample_ready = (level_reg != FULL_LEVEL);
    assign push         = sample_valid && sample_ready;
    assign pop          = (state_reg == RUN) && sample_tick && (level_reg != '0);
    assign tick_empty   = (state_reg == RUN) && sample_tick && (level_reg == '0);

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    // Sample storage carries no reset so it maps onto plain RAM/LUT storage.
    always_ff @(posedge clk50MHz) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sample_in;
        end
    end

    // Volume is an arithmetic shift of the sample re-centred around zero.
    assign centered = $signed({1'b0, cur_sample_reg}) - 9'sd128;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shifted[gi] = 8'(centered >>> gi);
        end
    endgenerate

    assign target_level = mute ? MIDSCALE : (shifted[volume] + MIDSCALE);

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            state_reg      <= RAMP_UP;
            ramp_cnt_reg   <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            cur_sample_reg <= MIDSCALE;
            lvl_reg        <= '0;
            underrun_reg   <= 1'b0;
        end else begin
            level_reg    <= level_next;
            underrun_reg <= tick_empty;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
                cur_sample_reg <= fifo_mem[rd_ptr_reg];
            end
            case (state_reg)
                RAMP_UP: begin
                    if (ramp_cnt_reg == RAMP_LAST) begin
                        ramp_cnt_reg <= '0;
                        lvl_reg      <= lvl_reg + 8'd1;
                        if (lvl_reg == MIDSCALE - 8'd1) begin
                            state_reg <= RUN;
                        end
                    end else begin
                        ramp_cnt_reg <= ramp_cnt_reg + RAMP_W'(1);
                    end
                end
                default: begin
                    lvl_reg <= target_level;
                end
            endcase
        end
    end

    // The carry out of the 8-bit accumulator is the sigma-delta bit; both the
    // accumulator and PWM counter free-run so a mode switch never resets them.
    assign sd_sum = {1'b0, acc_reg} + {1'b0, lvl_reg};

    always_ff @(posedge clk50MHz or posedge reset) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
            pwm_lvl_reg <= '0;
            acc_reg     <= '0;
            pdm_reg     <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            if (pwm_cnt_reg == 8'hFF) begin
                pwm_lvl_reg <= lvl_reg;
            end
            acc_reg <= sd_sum[7:0];
            pdm_reg <= mode ? sd_sum[8] : (pwm_cnt_reg < pwm_lvl_reg);
        end
    end

    assign underrun   = underrun_reg;
    assign fifo_level = level_reg;
    assign pdm_out    = pdm_reg;

endmodule

// File: tb/tb_audio_pdm_dac.sv
// Bench for audio_pdm_dac: a queue/arithmetic model checked every cycle, plus
// duty-cycle counts over 256-cycle windows against hand-computed values.
module tb_audio_pdm_dac;

    localparam int DEPTH = 4;
    localparam int RDIV  = 4;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic [7:0] sample_in    = 8'h00;
    logic       sample_valid = 1'b0;
    logic       sample_tick  = 1'b0;
    logic       mode         = 1'b0;
    logic [2:0] volume       = 3'd0;
    logic       mute         = 1'b0;
    logic       sample_ready;
    logic       underrun;
    logic [2:0] fifo_level;
    logic       pdm_out;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    logic [7:0] mq[$];
    int m_cyc, m_lvl, m_cur, m_latched, m_phase;
    bit m_run, m_under, m_pdm;

    audio_pdm_dac #(.FIFO_DEPTH(DEPTH), .RAMP_DIV(RDIV)) dut (
        .clk50MHz    (clk),
        .reset       (reset),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_tick (sample_tick),
        .mode        (mode),
        .volume      (volume),
        .mute        (mute),
        .underrun    (underrun),
        .fifo_level  (fifo_level),
        .pdm_out     (pdm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int target(input int cur, input int vol, input bit mt);
        int s;
        if (mt) return 128;
        s = cur - 128;
        s = s >>> vol;
        return (s + 128) & 255;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cyc = 0; m_lvl = 0; m_cur = 128; m_latched = 0; m_phase = 0;
        m_run = 1'b0; m_under = 1'b0; m_pdm = 1'b0;
    endtask

    task automatic model_step();
        int cnt;
        bit push_ok;
        bit next_run;
        cnt      = m_cyc % 256;
        push_ok  = sample_valid && (mq.size() < DEPTH);
        next_run = m_run;
        if (mode) m_pdm = (m_phase + m_lvl) >= 256;
        else      m_pdm = cnt < m_latched;
        m_phase = (m_phase + m_lvl) % 256;
        if (cnt == 255) m_latched = m_lvl;
        m_under = 1'b0;
        if (m_run) begin
            m_lvl = target(m_cur, int'(volume), mute);
        end else begin
            m_lvl = (m_cyc + 1) / RDIV;
            if (m_lvl == 128) next_run = 1'b1;
        end
        if (m_run && sample_tick) begin
            if (mq.size() > 0) begin
                m_cur = int'(mq.pop_front());
                $display("tick: play %02h", m_cur);
            end else begin
                m_under = 1'b1;
                $display("tick: fifo empty, underrun");
            end
        end
        if (push_ok) begin
            mq.push_back(sample_in);
            $display("push %02h level=%0d", sample_in, mq.size());
        end
        m_run = next_run;
        m_cyc = m_cyc + 1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("fifo_level", 32'(fifo_level), 32'(mq.size()));
                check("sample_ready", 32'(sample_ready), 32'(mq.size() != DEPTH));
                check("underrun", 32'(underrun), 32'(m_under));
                check("pdm_out", 32'(pdm_out), 32'(m_pdm));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input logic [7:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        cycle();
        sample_tick = 1'b0;
    endtask

    task automatic window(input int n, input int tick_every, output int highs, output int unders);
        highs  = 0;
        unders = 0;
        for (int i = 0; i < n; i++) begin
            sample_tick = (tick_every > 0) && ((i % tick_every) == tick_every - 1);
            cycle();
            if (pdm_out)  highs++;
            if (underrun) unders++;
        end
        sample_tick = 1'b0;
    endtask

    int c, u, found;
    int play_exp[4] = '{192, 64, 255, 0};
    logic [7:0] play_in[4] = '{8'hC0, 8'h40, 8'hFF, 8'h00};

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ready", 32'(sample_ready), 1);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_pdm", 32'(pdm_out), 0);
        reset = 1'b0;

        // Startup ramp: PWM duty per aligned period tracks lvl = cycles/RAMP_DIV.
        window(256, 7, c, u); check("ramp_win0", c, 0);   check("ramp_tick_underrun0", u, 0);
        window(256, 7, c, u); check("ramp_win1", c, 63);  check("ramp_tick_underrun1", u, 0);
        window(256, 0, c, u); check("ramp_win2", c, 127);
        window(256, 0, c, u); check("ramp_win3", c, 128);

        // Fill, overfill, drain in order.
        for (int i = 0; i < 4; i++) push(play_in[i]);
        check("full_level", 32'(fifo_level), 4);
        check("full_ready", 32'(sample_ready), 0);
        push(8'h11);
        check("refused_level", 32'(fifo_level), 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            settle(300);
            window(256, 0, c, u);
            check("play_order", c, play_exp[i]);
        end
        check("drained_level", 32'(fifo_level), 0);

        // Volume scaling.
        push(8'hC0); tick(); volume = 3'd1; settle(300);
        window(256, 0, c, u); check("vol1_C0", c, 160);
        push(8'h40); tick(); settle(300);
        window(256, 0, c, u); check("vol1_40", c, 96);
        push(8'h00); tick(); volume = 3'd7; settle(300);
        window(256, 0, c, u); check("vol7_00", c, 127);

        // Sigma-delta density.
        volume = 3'd0; mode = 1'b1;
        push(8'h40); tick(); settle(5);
        window(256, 0, c, u); check("sd_40", c, 64);
        push(8'h00); tick(); settle(5);
        window(256, 0, c, u); check("sd_00", c, 0);

        // Underrun handling.
        push(8'h40); tick(); settle(5);
        tick();
        check("underrun_pulse", 32'(underrun), 1);
        cycle();
        check("underrun_clear", 32'(underrun), 0);
        window(256, 0, c, u); check("lvl_held", c, 64);
        sample_in = 8'hC0; sample_valid = 1'b1; sample_tick = 1'b1;
        cycle();
        sample_valid = 1'b0; sample_tick = 1'b0;
        check("sim_underrun", 32'(underrun), 1);
        check("sim_level", 32'(fifo_level), 1);

        // Mute forces midscale.
        mode = 1'b0;
        tick();
        push(8'hFF); tick(); settle(300);
        window(256, 0, c, u); check("full_scale", c, 255);
        mute = 1'b1; settle(300);
        window(256, 0, c, u); check("mute_mid", c, 128);
        mute = 1'b0;

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                mode   = 1'($urandom_range(0, 1));
                volume = 3'($urandom_range(0, 7));
                mute   = ($urandom_range(0, 3) == 0);
            end
            sample_in    = 8'($urandom);
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_tick  = ($urandom_range(0, 11) == 0);
            cycle();
        end
        sample_valid = 1'b0; sample_tick = 1'b0;
        mode = 1'b0; volume = 3'd0; mute = 1'b0;

        // Reset mid-stream.
        repeat (DEPTH) tick();
        push(8'hFF); tick();
        push(8'h33); push(8'h44);
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            cycle();
            if (pdm_out) found = 1;
        end
        check("pre_reset_pdm_high", found, 1);
        reset = 1'b1;
        #1;
        check("midrst_pdm", 32'(pdm_out), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_ready", 32'(sample_ready), 1);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b0;
        push(8'h11); push(8'h22);
        check("ramp_push_level", 32'(fifo_level), 2);
        settle(254);
        window(256, 5, c, u);
        check("restart_ramp_win1", c, 63);
        check("restart_ramp_underrun", u, 0);
        check("ramp_ticks_ignored", 32'(fifo_level), 2);
        settle(300);
        tick(); tick(); settle(4);
        check("post_ramp_drain", 32'(fifo_level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
